// File: rtl/laser_pkg.sv
// Shared constants and read-side state type for the laser point frame player.
package laser_pkg;

  localparam int DEF_COORD_W    = 16;
  localparam int DEF_COLOR_W    = 8;
  localparam int DEF_NUM_COLORS = 3;
  localparam int DEF_DEPTH      = 2048;
  localparam int DEF_PERIOD_W   = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } play_state_e;

endpackage

// File: rtl/frame_bank_ram.sv
// Simple dual-port RAM holding both frame banks; the bank select is the address MSB.
module frame_bank_ram #(
  parameter int ADDR_W = 12,
  parameter int WORD_W = 56
) (
  input  logic              clock_in,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [2**ADDR_W];

  // Write port and registered read port (one cycle of read latency).
  always_ff @(posedge clock_in) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/point_frame_player.sv
// Double-buffered point frame player: a writer fills the back bank while the
// read FSM replays the front bank at a programmable clocks-per-point rate.
module point_frame_player
  import laser_pkg::*;
#(
  parameter int COORD_W    = DEF_COORD_W,
  parameter int COLOR_W    = DEF_COLOR_W,
  parameter int NUM_COLORS = DEF_NUM_COLORS,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int PERIOD_W   = DEF_PERIOD_W
) (
  input  logic                          clock_in,
  input  logic                          reset_n_in,
  input  logic [PERIOD_W-1:0]           point_period_in,
  input  logic                          loop_en_in,
  input  logic                          wr_valid_in,
  output logic                          wr_ready_out,
  input  logic [COORD_W-1:0]            wr_x_in,
  input  logic [COORD_W-1:0]            wr_y_in,
  input  logic [NUM_COLORS*COLOR_W-1:0] wr_color_in,
  input  logic                          wr_last_in,
  output logic                          pt_strobe_out,
  output logic [COORD_W-1:0]            pt_x_out,
  output logic [COORD_W-1:0]            pt_y_out,
  output logic [NUM_COLORS*COLOR_W-1:0] pt_color_out,
  output logic                          frame_sync_out,
  output logic                          overflow_out,
  output logic                          frame_pending_out
);

  localparam int AW     = $clog2(DEPTH);
  localparam int CLR_W  = NUM_COLORS * COLOR_W;
  localparam int WORD_W = 2 * COORD_W + CLR_W;

  // Periods below 2 clocks are clamped up to 2.
  function automatic logic [PERIOD_W-1:0] sat_period(input logic [PERIOD_W-1:0] p);
    return (p < PERIOD_W'(2)) ? PERIOD_W'(2) : p;
  endfunction

  logic [AW-1:0]     wr_ptr_q;
  logic [AW:0]       frame_len_q;
  logic              pending_q, drop_q, overflow_q;
  logic              wr_fire, wr_en, commit;

  play_state_e       state_q;
  logic              front_q;
  logic [AW-1:0]     rd_idx_q;
  logic [AW:0]       play_len_q;
  logic [PERIOD_W-1:0] cnt_q;
  logic              boundary, at_end, swap, relaunch, advance, stop;

  logic              rd_en_p0, first_p0, blank_p0;
  logic [AW:0]       rd_addr_p0;
  logic              vld_p1, first_p1, blank_p1;
  logic [WORD_W-1:0] rd_data_p1;

  // A committed frame blocks further writes until it has been swapped in.
  assign wr_ready_out      = ~pending_q;
  assign wr_fire           = wr_valid_in & ~pending_q;
  assign wr_en             = wr_fire & ~drop_q;
  assign commit            = wr_fire & wr_last_in & ~drop_q;
  assign overflow_out      = overflow_q;
  assign frame_pending_out = pending_q;

  assign boundary = (state_q == ST_PLAY) && (cnt_q == '0);
  assign at_end   = ({1'b0, rd_idx_q} == (play_len_q - (AW+1)'(1)));
  assign swap     = ((state_q == ST_IDLE) && pending_q) || (boundary && at_end && pending_q);
  assign relaunch = boundary && at_end && !pending_q && loop_en_in;
  assign stop     = boundary && at_end && !pending_q && !loop_en_in;
  assign advance  = boundary && !at_end;

  // Writer: fill the back bank, commit on last, drop the rest of an oversized frame.
  // The DEPTH-th point without last means the frame cannot fit, so overflow is flagged there.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      wr_ptr_q    <= '0;
      frame_len_q <= '0;
      pending_q   <= 1'b0;
      drop_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      overflow_q <= 1'b0;
      if (wr_fire) begin
        if (wr_last_in) begin
          wr_ptr_q <= '0;
          drop_q   <= 1'b0;
        end else if (!drop_q) begin
          if (wr_ptr_q == AW'(DEPTH - 1)) begin
            overflow_q <= 1'b1;
            drop_q     <= 1'b1;
            wr_ptr_q   <= '0;
          end else begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
          end
        end
      end
      if (commit) begin
        frame_len_q <= {1'b0, wr_ptr_q} + (AW+1)'(1);
        pending_q   <= 1'b1;
      end else if (swap) begin
        pending_q <= 1'b0;
      end
    end
  end

  frame_bank_ram #(
    .ADDR_W (AW + 1),
    .WORD_W (WORD_W)
  ) u_ram (
    .clock_in (clock_in),
    .wr_en    (wr_en),
    .wr_addr  ({~front_q, wr_ptr_q}),
    .wr_data  ({wr_x_in, wr_y_in, wr_color_in}),
    .rd_en    (rd_en_p0),
    .rd_addr  (rd_addr_p0),
    .rd_data  (rd_data_p1)
  );

  // Read FSM: period countdown per point, frame-end choice of swap / loop / idle.
  // Stage p0: read request, frame-start and blank markers issued here.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q    <= ST_IDLE;
      front_q    <= 1'b0;
      rd_idx_q   <= '0;
      play_len_q <= '0;
      cnt_q      <= '0;
      rd_en_p0   <= 1'b0;
      first_p0   <= 1'b0;
      blank_p0   <= 1'b0;
      rd_addr_p0 <= '0;
    end else begin
      rd_en_p0 <= swap | relaunch | advance;
      first_p0 <= swap | relaunch;
      blank_p0 <= stop;
      if (swap) begin
        state_q    <= ST_PLAY;
        front_q    <= ~front_q;
        play_len_q <= frame_len_q;
        rd_idx_q   <= '0;
        rd_addr_p0 <= {~front_q, {AW{1'b0}}};
        cnt_q      <= sat_period(point_period_in) - PERIOD_W'(1);
      end else if (relaunch) begin
        rd_idx_q   <= '0;
        rd_addr_p0 <= {front_q, {AW{1'b0}}};
        cnt_q      <= sat_period(point_period_in) - PERIOD_W'(1);
      end else if (advance) begin
        rd_idx_q   <= rd_idx_q + AW'(1);
        rd_addr_p0 <= {front_q, rd_idx_q + AW'(1)};
        cnt_q      <= sat_period(point_period_in) - PERIOD_W'(1);
      end else if (stop) begin
        state_q <= ST_IDLE;
      end else if (state_q == ST_PLAY) begin
        cnt_q <= cnt_q - PERIOD_W'(1);
      end
    end
  end

  // Stage p1: markers travel alongside the RAM read data.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      vld_p1   <= 1'b0;
      first_p1 <= 1'b0;
      blank_p1 <= 1'b0;
    end else begin
      vld_p1   <= rd_en_p0;
      first_p1 <= first_p0;
      blank_p1 <= blank_p0;
    end
  end

  // Output stage: present the point with its strobe, blank colour when play stops.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      pt_strobe_out  <= 1'b0;
      pt_x_out       <= '0;
      pt_y_out       <= '0;
      pt_color_out   <= '0;
      frame_sync_out <= 1'b0;
    end else begin
      pt_strobe_out <= vld_p1;
      if (vld_p1) begin
        {pt_x_out, pt_y_out, pt_color_out} <= rd_data_p1;
      end else if (blank_p1) begin
        pt_color_out <= '0;
      end
      if (vld_p1 && first_p1) frame_sync_out <= ~frame_sync_out;
    end
  end

endmodule

// File: tb/tb_point_frame_player.sv
// Bench for point_frame_player: table of playback scenarios plus corner sequences.
module tb_point_frame_player;

  localparam int CW   = 16;
  localparam int KW   = 8;
  localparam int NC   = 3;
  localparam int D    = 8;
  localparam int PW   = 16;
  localparam int CLRW = NC * KW;

  typedef struct {
    int npts;
    int period;
    bit loop;
    int nstr;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [PW-1:0]   period = 16'd4;
  logic            loop_en = 1'b0;
  logic            wr_valid = 1'b0;
  logic            wr_ready;
  logic [CW-1:0]   wr_x = '0, wr_y = '0;
  logic [CLRW-1:0] wr_c = '0;
  logic            wr_last = 1'b0;
  logic            strobe;
  logic [CW-1:0]   px, py;
  logic [CLRW-1:0] pc;
  logic            fsync, ovf, pend;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ovf_cnt = 0;

  logic [CW-1:0]   fx [2][16];
  logic [CW-1:0]   fy [2][16];
  logic [CLRW-1:0] fc [2][16];

  int mp_f [5] = '{0, 0, 1, 1, 1};
  int mp_i [5] = '{1, 2, 0, 1, 0};

  point_frame_player #(
    .COORD_W(CW), .COLOR_W(KW), .NUM_COLORS(NC), .DEPTH(D), .PERIOD_W(PW)
  ) dut (
    .clock_in          (clk),
    .reset_n_in        (rst_n),
    .point_period_in   (period),
    .loop_en_in        (loop_en),
    .wr_valid_in       (wr_valid),
    .wr_ready_out      (wr_ready),
    .wr_x_in           (wr_x),
    .wr_y_in           (wr_y),
    .wr_color_in       (wr_c),
    .wr_last_in        (wr_last),
    .pt_strobe_out     (strobe),
    .pt_x_out          (px),
    .pt_y_out          (py),
    .pt_color_out      (pc),
    .frame_sync_out    (fsync),
    .overflow_out      (ovf),
    .frame_pending_out (pend)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (ovf) ovf_cnt <= ovf_cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pt(input int f, input int i);
    return {8'h00, fx[f][i], fy[f][i], fc[f][i]};
  endfunction

  function automatic logic [63:0] shown();
    return {8'h00, px, py, pc};
  endfunction

  task automatic gen_frame(input int f, input int n);
    for (int i = 0; i < n; i++) begin
      fx[f][i] = CW'($urandom) | CW'(1);
      fy[f][i] = CW'($urandom);
      fc[f][i] = CLRW'($urandom) | CLRW'(1);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    wr_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic write_point(input int f, input int i, input bit last);
    int guard;
    guard = 0;
    wr_valid = 1'b1;
    wr_x = fx[f][i];
    wr_y = fy[f][i];
    wr_c = fc[f][i];
    wr_last = last;
    while (!wr_ready && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (!wr_ready) check("wr_ready_timeout", wr_ready, 1);
    @(posedge clk);
    @(negedge clk);
    wr_valid = 1'b0;
    wr_last = 1'b0;
  endtask

  task automatic write_frame(input int f, input int n, input bit last_at_end, output int ccyc);
    for (int i = 0; i < n; i++) write_point(f, i, last_at_end && (i == n - 1));
    ccyc = cyc;
  endtask

  task automatic wait_strobe(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (strobe) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("strobe_timeout", got, 1);
  endtask

  initial begin
    vec_t vecs [6];
    int   ccyc, last_cyc, eff, n, extra, k;
    bit   got, es;

    vecs[0] = '{3, 4, 1'b0, 3};
    vecs[1] = '{2, 3, 1'b1, 8};
    vecs[2] = '{1, 5, 1'b1, 4};
    vecs[3] = '{1, 2, 1'b0, 1};
    vecs[4] = '{4, 0, 1'b1, 8};
    vecs[5] = '{5, 7, 1'b0, 5};

    do_reset();
    check("rst_ready", wr_ready, 1);
    check("rst_strobe", strobe, 0);
    check("rst_point", shown(), 0);
    check("rst_sync", fsync, 0);
    check("rst_pending", pend, 0);
    check("rst_overflow", ovf, 0);

    // Table-driven playback scenarios against the arithmetic model.
    foreach (vecs[v]) begin
      do_reset();
      n = vecs[v].npts;
      period = PW'(vecs[v].period);
      loop_en = vecs[v].loop;
      eff = (vecs[v].period < 2) ? 2 : vecs[v].period;
      gen_frame(0, n);
      write_frame(0, n, 1'b1, ccyc);
      es = 1'b0;
      last_cyc = 0;
      for (int i = 0; i < vecs[v].nstr; i++) begin
        wait_strobe(3 * eff + 8, got);
        if (!got) break;
        if (i == 0) check("start_latency", (cyc - ccyc >= 1) && (cyc - ccyc <= 3), 1);
        else check("spacing", cyc - last_cyc, eff);
        last_cyc = cyc;
        check("point", shown(), pt(0, i % n));
        if (i % n == 0) es = ~es;
        check("frame_sync", fsync, es);
      end
      if (!vecs[v].loop) begin
        extra = 0;
        for (int j = 0; j < eff + 3; j++) begin
          @(negedge clk);
          if (strobe) extra++;
        end
        check("idle_no_strobe", extra, 0);
        check("idle_color", pc, 0);
        check("idle_hold_xy", {px, py}, {fx[0][n-1], fy[0][n-1]});
        check("idle_ready", wr_ready, 1);
      end
    end

    // New frame committed during playback: swap only at the frame end.
    do_reset();
    period = 16'd4;
    loop_en = 1'b1;
    gen_frame(0, 3);
    gen_frame(1, 2);
    write_frame(0, 3, 1'b1, ccyc);
    wait_strobe(20, got);
    check("mp_a0", shown(), pt(0, 0));
    es = 1'b1;
    write_frame(1, 2, 1'b1, ccyc);
    check("mp_pending", pend, 1);
    check("mp_ready_low", wr_ready, 0);
    for (int j = 0; j < 5; j++) begin
      wait_strobe(20, got);
      if (!got) break;
      check("mp_point", shown(), pt(mp_f[j], mp_i[j]));
      if (mp_i[j] == 0) es = ~es;
      check("mp_sync", fsync, es);
      if (j == 1) check("mp_ready_before_swap", wr_ready, 0);
      if (j == 2) check("mp_ready_after_swap", wr_ready, 1);
    end

    // Oversized frame: one overflow pulse, nothing committed, display untouched.
    do_reset();
    period = 16'd3;
    loop_en = 1'b1;
    gen_frame(0, 2);
    write_frame(0, 2, 1'b1, ccyc);
    wait_strobe(20, got);
    k = ovf_cnt;
    gen_frame(1, D + 5);
    write_frame(1, D + 5, 1'b1, ccyc);
    repeat (2) @(negedge clk);
    check("ovf_pulses", ovf_cnt - k, 1);
    check("ovf_no_commit", pend, 0);
    check("ovf_ready", wr_ready, 1);
    wait_strobe(20, got);
    k = (shown() == pt(0, 1)) ? 1 : 0;
    check("ovf_display", shown(), pt(0, k));
    for (int j = 1; j < 4; j++) begin
      wait_strobe(20, got);
      check("ovf_display", shown(), pt(0, (k + j) % 2));
    end
    gen_frame(1, 2);
    write_frame(1, 2, 1'b1, ccyc);
    got = 1'b0;
    for (int j = 0; j < 6 && !got; j++) begin
      wait_strobe(20, es);
      if (shown() == pt(1, 0)) got = 1'b1;
    end
    check("ovf_recover_swap", got, 1);

    // Period 4 -> 8 change mid-point takes effect from the next strobe.
    do_reset();
    period = 16'd4;
    loop_en = 1'b0;
    gen_frame(0, 6);
    write_frame(0, 6, 1'b1, ccyc);
    wait_strobe(20, got);
    last_cyc = cyc;
    period = 16'd8;
    wait_strobe(20, got);
    check("per_old", cyc - last_cyc, 4);
    last_cyc = cyc;
    wait_strobe(20, got);
    check("per_new", cyc - last_cyc, 8);
    last_cyc = cyc;
    wait_strobe(20, got);
    check("per_new2", cyc - last_cyc, 8);

    // Asynchronous reset mid-frame and mid-write.
    do_reset();
    period = 16'd5;
    loop_en = 1'b1;
    gen_frame(0, 3);
    write_frame(0, 3, 1'b1, ccyc);
    wait_strobe(20, got);
    gen_frame(1, 2);
    write_frame(1, 2, 1'b0, ccyc);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_point", shown(), 0);
    check("arst_strobe", strobe, 0);
    check("arst_sync", fsync, 0);
    check("arst_pending", pend, 0);
    check("arst_ready", wr_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (strobe) extra++;
    end
    check("arst_idle", extra, 0);
    check("arst_ready_after", wr_ready, 1);
    gen_frame(1, 1);
    write_frame(1, 1, 1'b1, ccyc);
    wait_strobe(20, got);
    check("arst_new_frame", shown(), pt(1, 0));
    last_cyc = cyc;
    for (int j = 0; j < 2; j++) begin
      wait_strobe(20, got);
      check("arst_single_point", shown(), pt(1, 0));
      check("arst_single_spacing", cyc - last_cyc, 5);
      last_cyc = cyc;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/point_frame_player.md
POINT_FRAME_PLAYER -- requirements
Module: point_frame_player

Interface
REQ-001 SHALL have parameter COORD_W, default 16, X/Y coordinate width in bits.
REQ-002 SHALL have parameter COLOR_W, default 8, width of one colour channel in bits.
REQ-003 SHALL have parameter NUM_COLORS, default 3, number of colour channels; channel 0 sits in the LSBs.
REQ-004 SHALL have parameter DEPTH, default 2048, maximum points per frame; must be a power of two and at least 2.
REQ-005 SHALL have parameter PERIOD_W, default 16, width of the point period.
REQ-006 SHALL have port clock_in  input  1  the single clock for all logic.
REQ-007 SHALL have port reset_n_in  input  1  reset; asynchronous, active-low.
REQ-008 SHALL have port point_period_in  input  PERIOD_W  clocks per displayed point.
REQ-009 SHALL have port loop_en_in  input  1  replay the current frame while no new frame is pending.
REQ-010 SHALL have port wr_valid_in / wr_ready_out  input/output  1  handshake for writing points.
REQ-011 SHALL have ports wr_x_in, wr_y_in  input  COORD_W  coordinates of the point being written.
REQ-012 SHALL have port wr_color_in  input  NUM_COLORS*COLOR_W  colour of the point being written.
REQ-013 SHALL have port wr_last_in  input  1  marks the final point of a frame.
REQ-014 SHALL have port pt_strobe_out  output  1  one-cycle pulse when a new point is presented.
REQ-015 SHALL have ports pt_x_out, pt_y_out, pt_color_out  output  COORD_W/COORD_W/NUM_COLORS*COLOR_W  the displayed point.
REQ-016 SHALL have port frame_sync_out  output  1  toggles at every frame start.
REQ-017 SHALL have ports overflow_out, frame_pending_out  output  1  overflow pulse; committed frame awaiting display.

Function
REQ-018 SHALL accept a point on any cycle with wr_valid_in=1 and wr_ready_out=1, writing it to the back bank at index wr_ptr, then incrementing wr_ptr.
REQ-019 SHALL, when the accepted point has wr_last_in=1, record the frame length as wr_ptr+1, set frame_pending_out, reset wr_ptr to 0, and hold wr_ready_out=0 until the next swap.
REQ-020 SHALL, on accepting point DEPTH with wr_last_in=0, pulse overflow_out for one cycle, then accept and discard points up to and including the next one with wr_last_in=1; that frame is never committed.
REQ-021 SHALL run the read side as a two-state FSM: IDLE and PLAY.
REQ-022 SHALL, in IDLE, hold pt_color_out=0, hold the last pt_x_out and pt_y_out values, and keep pt_strobe_out=0.
REQ-023 SHALL, in IDLE with frame_pending_out=1, swap banks, clear pending, toggle frame_sync_out, and present index 0 within 3 cycles.
REQ-024 SHALL, in PLAY, present one point every max(point_period_in, 2) clocks, with registered outputs updating in the pt_strobe_out cycle and holding otherwise.
REQ-025 SHALL sample point_period_in only at point boundaries.
REQ-026 SHALL, when the period of the last point in a frame expires, choose one of three actions in priority order:
  - pending=1: swap banks and start at index 0;
  - otherwise loop_en_in=1: restart the same bank at index 0;
  - otherwise: go to IDLE with colour blanked.
REQ-027 SHALL toggle frame_sync_out at every frame start, whether from a swap or a loop.
REQ-028 SHALL make a frame commit only visible from the cycle after the commit; a commit in the same cycle as the frame-end decision SHALL take effect at the following frame end.
REQ-029 SHALL handle a 1-point frame correctly: the point is strobed once per period and frames loop or swap normally.
REQ-030 SHALL never write to the front bank, so the displayed frame never tears.

Reset
REQ-031 SHALL, while reset_n_in=0, force immediately:
  - pt_* outputs to 0;
  - frame_sync_out, overflow_out and frame_pending_out to 0;
  - wr_ready_out to 1;
  - the FSM to IDLE, the front bank to bank 0, and wr_ptr to 0.
REQ-032 SHALL discard a partially written frame when reset is asserted mid-write.

Structure
REQ-033 SHALL take default parameter constants and the read-FSM state enum from the shared package laser_pkg.
REQ-034 SHALL store both banks in one sub-module, frame_bank_ram: a simple dual-port RAM of 2*DEPTH words with 1-cycle read latency, where the bank bit is the address MSB.
REQ-035 SHALL store each word as {x, y, color}.

Verification
REQ-036 SHALL cover: write 3 points (the last one flagged), point_period_in=4, loop_en_in=0 -> strobes at 4-cycle spacing with points 0, 1, 2; frame_sync_out toggles once; then IDLE with colour 0.
REQ-037 SHALL cover: loop_en_in=1 with 2 points and period 3 -> indices 0, 1, 0, 1 repeating; frame_sync_out toggles every 6 cycles.
REQ-038 SHALL cover: a new frame committed mid-playback -> wr_ready_out=0 until the current frame end, a swap at that boundary, and no mixed points.
REQ-039 SHALL cover: DEPTH+5 points with last on the final one -> one overflow_out pulse, no commit, display unchanged.
REQ-040 SHALL cover: point_period_in=0 -> period 2 used; a period change from 4 to 8 mid-point applies at the next strobe.
REQ-041 SHALL cover: reset_n_in asserted mid-frame and mid-write -> outputs 0 asynchronously; after release wr_ready_out=1 and the FSM is IDLE.
